// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker: a lone eligible port wins; on a tie the port
// that did not win last time is chosen.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic eligA,
  input  logic eligB,
  input  logic lastGrant,
  output logic grant,
  output logic grantValid
);

  always_comb begin
    grantValid = eligA | eligB;
    grant      = PORT_A;
    if (eligA && eligB) begin
      grant = ~lastGrant;
    end else if (eligB) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM between a debug port (A) and the core (B): fixed-length
// accesses with WAIT_CYCLES enable cycles, round-robin on conflict, core pause.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_aReq,
  input  logic        i_aWr,
  input  logic [15:0] i_aAddr,
  input  logic [15:0] i_aData,
  output logic        o_aAck,
  output logic [15:0] o_aData,
  input  logic        i_bReq,
  input  logic        i_bWr,
  input  logic [15:0] i_bAddr,
  input  logic [15:0] i_bData,
  output logic        o_bAck,
  output logic [15:0] o_bData,
  input  logic        i_pause,
  output logic        o_pauseSafe,
  output logic [15:0] o_memAddr,
  output logic        o_memWr,
  output logic        o_memEn,
  output logic [15:0] o_memDataOut,
  output logic        o_memDataOE,
  input  logic [15:0] i_memData,
  output logic [1:0]  o_dbgState
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("mem_arbiter: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        pause_safe_q, pause_safe_d;
  logic        pick_grant, pick_valid;

  mem_arb_pick u_pick (
    .eligA      (i_aReq),
    .eligB      (i_bReq & ~i_pause),
    .lastGrant  (grant_q),
    .grant      (pick_grant),
    .grantValid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          wr_d    = (pick_grant == PORT_A) ? i_aWr   : i_bWr;
          addr_d  = (pick_grant == PORT_A) ? i_aAddr : i_bAddr;
          wdata_d = (pick_grant == PORT_A) ? i_aData : i_bData;
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            if (grant_q == PORT_A) a_rdata_d = i_memData;
            else                   b_rdata_d = i_memData;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // grant_q doubles as lastGrant; it is only meaningful for safety while busy
    pause_safe_d = i_pause & ~((state_q != ST_IDLE) & (grant_q == PORT_B));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= PORT_B;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      a_rdata_q    <= 16'h0000;
      b_rdata_q    <= 16'h0000;
      pause_safe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      pause_safe_q <= pause_safe_d;
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign o_memEn      = (state_q == ST_ACCESS);
  assign o_memWr      = (state_q == ST_ACCESS) & wr_q;
  assign o_memDataOE  = (state_q == ST_ACCESS) & wr_q;
  assign o_memAddr    = addr_q;
  assign o_memDataOut = wdata_q;
  assign o_aAck       = (state_q == ST_DONE) & (grant_q == PORT_A);
  assign o_bAck       = (state_q == ST_DONE) & (grant_q == PORT_B);
  assign o_aData      = a_rdata_q;
  assign o_bData      = b_rdata_q;
  assign o_pauseSafe  = pause_safe_q;
  assign o_dbgState   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=3 share the requester inputs; each test checks one of them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        a_req, a_wr, b_req, b_wr, pause;
  logic [15:0] a_addr, a_data, b_addr, b_data, mem_rdata;

  logic        x1_a_ack, x1_b_ack, x1_pause_safe, x1_mem_wr, x1_mem_en, x1_mem_oe;
  logic [15:0] x1_a_data, x1_b_data, x1_mem_addr, x1_mem_dout;
  logic [1:0]  x1_dbg;
  logic        x3_a_ack, x3_b_ack, x3_pause_safe, x3_mem_wr, x3_mem_en, x3_mem_oe;
  logic [15:0] x3_a_data, x3_b_data, x3_mem_addr, x3_mem_dout;
  logic [1:0]  x3_dbg;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rstn(rstn),
    .i_aReq(a_req), .i_aWr(a_wr), .i_aAddr(a_addr), .i_aData(a_data),
    .o_aAck(x1_a_ack), .o_aData(x1_a_data),
    .i_bReq(b_req), .i_bWr(b_wr), .i_bAddr(b_addr), .i_bData(b_data),
    .o_bAck(x1_b_ack), .o_bData(x1_b_data),
    .i_pause(pause), .o_pauseSafe(x1_pause_safe),
    .o_memAddr(x1_mem_addr), .o_memWr(x1_mem_wr), .o_memEn(x1_mem_en),
    .o_memDataOut(x1_mem_dout), .o_memDataOE(x1_mem_oe),
    .i_memData(mem_rdata), .o_dbgState(x1_dbg)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn),
    .i_aReq(a_req), .i_aWr(a_wr), .i_aAddr(a_addr), .i_aData(a_data),
    .o_aAck(x3_a_ack), .o_aData(x3_a_data),
    .i_bReq(b_req), .i_bWr(b_wr), .i_bAddr(b_addr), .i_bData(b_data),
    .o_bAck(x3_b_ack), .o_bData(x3_b_data),
    .i_pause(pause), .o_pauseSafe(x3_pause_safe),
    .o_memAddr(x3_mem_addr), .o_memWr(x3_mem_wr), .o_memEn(x3_mem_en),
    .o_memDataOut(x3_mem_dout), .o_memDataOE(x3_mem_oe),
    .i_memData(mem_rdata), .o_dbgState(x3_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rstn  = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = 16'h0; a_data = 16'h0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = 16'h0; b_data = 16'h0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_wr = 1'b1; b_wr = 1'b1; pause = 1'b1;
    a_addr = 16'hFFFF; a_data = 16'hFFFF; mem_rdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({x3_a_ack, x3_b_ack, x3_pause_safe, x3_mem_wr, x3_mem_en, x3_mem_oe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {x3_a_ack, x3_b_ack, x3_pause_safe, x3_mem_wr, x3_mem_en, x3_mem_oe});
    end
    checks++;
    if ({x3_a_data, x3_b_data, x3_mem_addr, x3_mem_dout} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {x3_a_data, x3_b_data, x3_mem_addr, x3_mem_dout});
    end
    checks++;
    if (x3_dbg !== ST_IDLE || x1_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d expected 0/0", x1_dbg, x3_dbg);
    end
  endtask

  task automatic test_a_read_wc1();
    do_reset();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h1234; mem_rdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (x1_mem_en !== 1'b1 || x1_mem_addr !== 16'h1234 || x1_mem_oe !== 1'b0 || x1_a_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd1_access: got en=%b addr=%h oe=%b ack=%b expected en=1 addr=1234 oe=0 ack=0",
               x1_mem_en, x1_mem_addr, x1_mem_oe, x1_a_ack);
    end
    @(negedge clk);
    checks++;
    if (x1_a_ack !== 1'b1 || x1_a_data !== 16'hBEEF || x1_mem_en !== 1'b0 || x1_mem_oe !== 1'b0) begin
      errors++;
      $display("FAIL rd1_ack: got ack=%b data=%h en=%b oe=%b expected ack=1 data=beef en=0 oe=0",
               x1_a_ack, x1_a_data, x1_mem_en, x1_mem_oe);
    end
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (x1_a_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd1_ack_pulse: got %b expected 0", x1_a_ack);
    end
  endtask

  task automatic test_b_write();
    do_reset();
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h00FF; b_data = 16'hA5A5; mem_rdata = 16'h5555;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if ({x3_mem_en, x3_mem_wr, x3_mem_oe} !== 3'b111 || x3_mem_dout !== 16'hA5A5 ||
            x3_mem_addr !== 16'h00FF || x3_b_ack !== 1'b0) begin
          errors++;
          $display("FAIL wr_access c%0d: got en/wr/oe=%b dout=%h addr=%h ack=%b expected 111 a5a5 00ff 0",
                   c, {x3_mem_en, x3_mem_wr, x3_mem_oe}, x3_mem_dout, x3_mem_addr, x3_b_ack);
        end
      end else begin
        checks++;
        if (x3_b_ack !== (c == 4) || {x3_mem_en, x3_mem_wr, x3_mem_oe} !== 3'b000 ||
            x3_b_data !== 16'h0000) begin
          errors++;
          $display("FAIL wr_done c%0d: got ack=%b strobes=%b bdata=%h expected ack=%b 000 0000",
                   c, x3_b_ack, {x3_mem_en, x3_mem_wr, x3_mem_oe}, x3_b_data, (c == 4));
        end
      end
      if (c == 4) b_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_q[$];
    logic [5:0] seen;
    logic [5:0] exp_v;
    do_reset();
    exp_q = {};
    exp_q.push_back({1'b0, 5'd4});
    exp_q.push_back({1'b1, 5'd9});
    exp_q.push_back({1'b0, 5'd14});
    exp_q.push_back({1'b1, 5'd19});
    a_req = 1'b1; b_req = 1'b1; a_wr = 1'b0; b_wr = 1'b0; mem_rdata = 16'hC3C3;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (x3_a_ack === 1'b1 || x3_b_ack === 1'b1) begin
        seen = {x3_b_ack, 5'(c)};
        checks++;
        if (x3_a_ack === 1'b1 && x3_b_ack === 1'b1) begin
          errors++;
          $display("FAIL rr_dual_ack: got both acks at cycle %0d expected one", c);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra_ack: got %h expected none", seen);
        end else begin
          exp_v = exp_q.pop_front();
          if (seen !== exp_v) begin
            errors++;
            $display("FAIL rr_order: got port/cycle %h expected %h", seen, exp_v);
          end
        end
      end
      if (c == 19) begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_missing: got %0d acks outstanding expected 0", exp_q.size());
    end
    checks++;
    if (x3_a_data !== 16'hC3C3 || x3_b_data !== 16'hC3C3) begin
      errors++;
      $display("FAIL rr_rdata: got %h/%h expected c3c3/c3c3", x3_a_data, x3_b_data);
    end
  endtask

  task automatic test_pause();
    logic exp_aa, exp_ba, exp_ps;
    do_reset();
    b_req = 1'b1; b_wr = 1'b0; a_wr = 1'b0; mem_rdata = 16'h4444;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_aa = (c == 9) || (c == 14);
      exp_ba = (c == 4) || (c == 19);
      exp_ps = (c >= 6) && (c <= 14);
      checks++;
      if (x3_a_ack !== exp_aa || x3_b_ack !== exp_ba || x3_pause_safe !== exp_ps) begin
        errors++;
        $display("FAIL pause c%0d: got aack=%b back=%b safe=%b expected %b %b %b",
                 c, x3_a_ack, x3_b_ack, x3_pause_safe, exp_aa, exp_ba, exp_ps);
      end
      if (c == 4 || c == 19) begin
        checks++;
        if (x3_b_data !== ((c == 4) ? 16'h4444 : 16'h7777)) begin
          errors++;
          $display("FAIL pause_bdata c%0d: got %h expected %h", c, x3_b_data,
                   (c == 4) ? 16'h4444 : 16'h7777);
        end
      end
      if (c == 1) begin
        pause = 1'b1; a_req = 1'b1;
      end
      if (c == 14) begin
        pause = 1'b0; a_req = 1'b0; mem_rdata = 16'h7777;
      end
      if (c == 19) b_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 16'h0042; a_data = 16'h9999;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0077; b_data = 16'h6666;
    @(negedge clk);
    checks++;
    if ({x3_mem_en, x3_mem_wr, x3_mem_oe} !== 3'b111) begin
      errors++;
      $display("FAIL rst_pre: got %b expected 111", {x3_mem_en, x3_mem_wr, x3_mem_oe});
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({x3_mem_en, x3_mem_wr, x3_mem_oe} !== 3'b000 || x3_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_async: got strobes=%b state=%0d expected 000 0",
               {x3_mem_en, x3_mem_wr, x3_mem_oe}, x3_dbg);
    end
    @(negedge clk);
    checks++;
    if (x3_a_ack !== 1'b0 || x3_b_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_ack: got %b%b expected 00", x3_a_ack, x3_b_ack);
    end
    rstn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (x3_dbg !== ST_ACCESS || x3_mem_addr !== 16'h0042 || x3_mem_dout !== 16'h9999) begin
          errors++;
          $display("FAIL rst_regrant: got state=%0d addr=%h dout=%h expected 1 0042 9999",
                   x3_dbg, x3_mem_addr, x3_mem_dout);
        end
      end
      if (c == 4) begin
        checks++;
        if (x3_a_ack !== 1'b1 || x3_b_ack !== 1'b0) begin
          errors++;
          $display("FAIL rst_first_ack: got a=%b b=%b expected a=1 b=0", x3_a_ack, x3_b_ack);
        end
        a_req = 1'b0; b_req = 1'b0;
      end
    end
  endtask

  task automatic test_read_then_write();
    do_reset();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0001; mem_rdata = 16'h1111;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (x3_a_ack !== 1'b1 || x3_a_data !== 16'h1111) begin
          errors++;
          $display("FAIL rw_read: got ack=%b data=%h expected 1 1111", x3_a_ack, x3_a_data);
        end
        a_wr = 1'b1; a_data = 16'h2222; mem_rdata = 16'h3333;
      end
      if (c == 6) begin
        checks++;
        if (x3_mem_dout !== 16'h2222 || x3_mem_oe !== 1'b1 || x3_mem_addr !== 16'h0001) begin
          errors++;
          $display("FAIL rw_write_pins: got dout=%h oe=%b addr=%h expected 2222 1 0001",
                   x3_mem_dout, x3_mem_oe, x3_mem_addr);
        end
      end
      if (c == 9) begin
        checks++;
        if (x3_a_ack !== 1'b1 || x3_a_data !== 16'h1111) begin
          errors++;
          $display("FAIL rw_hold: got ack=%b data=%h expected 1 1111", x3_a_ack, x3_a_data);
        end
        a_req = 1'b0;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_a_read_wc1();
    test_b_write();
    test_back_to_back();
    test_pause();
    test_reset_mid_access();
    test_read_then_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences and shares the parallel-port runtime SRAM between two requesters: port A (JTAG/debug path) and port B (processor core).
- Runs a fixed-length SRAM access with configurable wait states.
- Arbitrates round-robin when both ports request at once.
- Blocks new core accesses while a pause is requested, and reports when the SRAM is quiescent for the core.
- Sits between the requesters and the top-level memory pins. The io_memData tristate buffer stays at top level, driven by o_memDataOut/o_memDataOE.

Parameters:
WAIT_CYCLES, 1, number of cycles the SRAM is enabled per access (legal 1..15)

Ports:
i_clk  input  1  system clock
i_rstn  input  1  asynchronous active-low reset
i_aReq  input  1  port A access request, held until acked
i_aWr  input  1  port A write (1) / read (0)
i_aAddr  input  16  port A word address
i_aData  input  16  port A write data
o_aAck  output  1  port A one-cycle completion pulse
o_aData  output  16  port A read data, valid from ack onward
i_bReq, i_bWr, i_bAddr, i_bData, o_bAck, o_bData  same as port A, for port B
i_pause  input  1  pause request (from synchronized i_smDoPause)
o_pauseSafe  output  1  high when i_pause=1 and no port B access in flight
o_memAddr  output  16  SRAM address
o_memWr  output  1  SRAM write strobe
o_memEn  output  1  SRAM enable
o_memDataOut  output  16  SRAM write data
o_memDataOE  output  1  drive io_memData when high
i_memData  input  16  SRAM read data

Behaviour:
- One clock; reset is asynchronous and active-low.
  - Reset values: all outputs 0. Internal: state IDLE, wait counter 0, lastGrant=B, so A wins the first conflict.
  - Reset mid-access aborts immediately. o_memEn, o_memWr and o_memDataOE drop asynchronously, and no ack is issued.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Eligible ports: A if i_aReq; B if i_bReq and !i_pause.
  - If none are eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the port that is not lastGrant.
  - On grant: latch addr, wr and data into registers; set lastGrant; load counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - Outputs: o_memEn=1, o_memAddr=latched addr, o_memWr=latched wr, o_memDataOut=latched data, o_memDataOE=latched wr.
  - The counter decrements each cycle.
  - At counter==0: if reading, capture i_memData into the granted port's read register at that edge; go to DONE.
- DONE:
  - o_memEn, o_memWr and o_memDataOE are 0.
  - The granted port's ack is 1 for this cycle only; next state is IDLE.
- Latency: request seen in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ack in cycle WAIT_CYCLES+1.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Requester rules:
  - Keep req, addr, wr and data stable from req assertion until the ack edge.
  - Deassert req on the cycle after the ack.
  - A req still high in the next IDLE is a new access.
  - A requester changing addr/data mid-access has no effect; values are latched at grant.
- o_aData/o_bData hold the last read value until the next read on that port; writes leave them unchanged.
- Pause:
  - i_pause rising during a port B access does not abort it; B completes normally.
  - o_pauseSafe = i_pause & !(state!=IDLE & grant==B), registered, one-cycle lag allowed.
  - Port A is served normally while paused.
  - Pending B requests are granted the first IDLE cycle after i_pause falls.
- Address and data pass through untouched; there is no arithmetic on the datapath.
- Counter is 4 bits and never wraps; it reloads at each grant.
- WAIT_CYCLES outside 1..15 is a configuration error; simulation asserts at elaboration.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - port index constants PORT_A=0, PORT_B=1
  - WAIT_CYCLES legal range constants
- Optional sub-module mem_arb_pick: combinational 2-way round-robin picker with inputs eligA, eligB, lastGrant and outputs grant, grantValid. Reused later for additional SRAM clients.

Test Plan:
1. Port A read only, WAIT_CYCLES=1:
   - Stimulus: i_aReq=1, addr 0x1234; SRAM model returns 0xBEEF.
   - Response: o_memEn=1 and o_memAddr=0x1234 in cycle 1; o_aAck=1 in cycle 2 with o_aData=0xBEEF; o_memDataOE stays 0.
2. Port B write, WAIT_CYCLES=3:
   - Stimulus: addr 0x00FF, data 0xA5A5.
   - Response: o_memEn=o_memWr=o_memDataOE=1 with o_memDataOut=0xA5A5 for exactly 3 cycles; o_bAck in cycle 4; o_bData unchanged.
3. Simultaneous requests held continuously:
   - Stimulus: A and B both request from reset.
   - Response: grants alternate A, B, A, B; each ack arrives WAIT_CYCLES+2 cycles apart.
4. Pause during a B access:
   - Stimulus: assert i_pause in cycle 1 of a B access while B and A keep requesting.
   - Response: B still acks; o_pauseSafe rises after DONE; only A is granted afterwards.
   - Stimulus: drop i_pause.
   - Response: B is granted in the next IDLE.
5. Reset asserted during ACCESS:
   - Response: o_memEn, o_memWr and o_memDataOE fall without waiting for a clock; no ack.
   - After release, the state is IDLE and a pending A request is granted first.
6. Read then write on port A:
   - Stimulus: read 0x0001 (0x1111), then write 0x0001.
   - Response: o_aData stays 0x1111 after the write ack.
